// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-sharing sequencer.
// Contents: ALU opcode constants, FSM state encoding and the legal-opcode check.
package alu_share_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] ctrl);
    case (ctrl)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Existing 32-bit combinational ALU; external interface is kept as-is.
// Ports:
//   rst_n        - active-low reset, forces result/flags to zero while asserted
//   src1, src2   - 32-bit operands
//   ALU_control  - 4-bit operation code (see alu_share_pkg)
//   result       - 32-bit result
//   zero         - result == 0
//   cout         - carry-out of ADD / SUB (src1 + ~src2 + 1), 0 otherwise
//   overflow     - signed overflow of ADD / SUB, 0 otherwise
module alu
  import alu_share_pkg::*;
(
  input  logic        rst_n,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [3:0]  ALU_control,
  output logic [31:0] result,
  output logic        zero,
  output logic        cout,
  output logic        overflow
);

  logic [32:0] sum;
  logic [32:0] diff;

  always_comb begin
    sum      = {1'b0, src1} + {1'b0, src2};
    diff     = {1'b0, src1} + {1'b0, ~src2} + 33'd1;
    result   = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    case (ALU_control)
      OP_AND:  result = src1 & src2;
      OP_OR:   result = src1 | src2;
      OP_NOR:  result = ~(src1 | src2);
      OP_NAND: result = ~(src1 & src2);
      OP_ADD: begin
        result   = sum[31:0];
        cout     = sum[32];
        overflow = (src1[31] == src2[31]) && (sum[31] != src1[31]);
      end
      OP_SUB: begin
        result   = diff[31:0];
        cout     = diff[32];
        overflow = (src1[31] != src2[31]) && (diff[31] != src1[31]);
      end
      OP_SLT:  result = {31'd0, $signed(src1) < $signed(src2)};
      default: ;
    endcase
    if (!rst_n) begin
      result   = '0;
      cout     = 1'b0;
      overflow = 1'b0;
    end
    zero = (result == 32'd0);
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin arbiter. Priority starts at ptr_i and wraps around;
// with ptr_i tied to zero it degenerates to fixed lowest-index-first priority.
// Ports:
//   req_i     - request vector
//   ptr_i     - index holding highest priority this cycle
//   en_i      - grant enable; no grant when low
//   gnt_o     - one-hot (or zero) grant
//   gnt_idx_o - encoded index of the grant (0 when no grant)
module alu_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o
);

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] pick;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      hi_mask[i] = (i >= int'(ptr_i));
    end
    // Requests at or above the pointer win first; otherwise wrap to the low ones.
    masked = req_i & hi_mask;
    pick   = (|masked) ? masked : req_i;

    gnt_o     = '0;
    gnt_idx_o = '0;
    if (en_i) begin
      // Descending scan so the lowest set bit of pick is the final writer.
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
        if (pick[i]) begin
          gnt_o     = '0;
          gnt_o[i]  = 1'b1;
          gnt_idx_o = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one 32-bit ALU between NUM_REQ requesters. A request is accepted in IDLE
// (or in RESP as the previous response is taken), evaluated for one cycle in EXEC,
// then returned with its requester ID over a valid/ready response channel.
// Build option: define ALU_SHARE_FIXED_PRIO_EN for fixed lowest-index-first
// priority (no pointer register); round-robin otherwise.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   req_valid/ready   - per-requester request handshake (ready is one-hot or zero)
//   req_src1/src2     - packed 32-bit operands, requester i at [32i+31:32i]
//   req_ctrl          - packed 4-bit ALU control codes
//   resp_valid/ready  - response handshake
//   resp_id           - requester index of the response
//   resp_result, resp_zero, resp_cout, resp_overflow - ALU result and flags
//   resp_illegal      - control code was not a supported opcode
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_src1,
  input  logic [NUM_REQ*32-1:0] req_src2,
  input  logic [NUM_REQ*4-1:0]  req_ctrl,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_result,
  output logic                  resp_zero,
  output logic                  resp_cout,
  output logic                  resp_overflow,
  output logic                  resp_illegal
);

  state_e            state_q;
  logic [31:0]       op_src1_q, op_src2_q;
  logic [3:0]        op_ctrl_q;
  logic [ID_W-1:0]   op_id_q;

  logic              resp_valid_q;
  logic [ID_W-1:0]   resp_id_q;
  logic [31:0]       resp_result_q;
  logic              resp_zero_q, resp_cout_q, resp_overflow_q, resp_illegal_q;

  logic [ID_W-1:0]    arb_ptr;
  logic               arb_en;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               hs;

  logic [31:0] sel_src1, sel_src2;
  logic [3:0]  sel_ctrl;

  logic [31:0] alu_result;
  logic        alu_zero, alu_cout, alu_overflow;

`ifdef ALU_SHARE_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [ID_W-1:0] ptr_q;
  assign arb_ptr = ptr_q;
`endif

  // Grants only where a request can be accepted; rst_n gating keeps ready low in reset.
  assign arb_en = rst_n &&
                  ((state_q == ST_IDLE) || ((state_q == ST_RESP) && resp_ready));

  alu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (arb_ptr),
    .en_i      (arb_en),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  assign req_ready = arb_gnt;
  // Grant implies valid, so any grant is a handshake.
  assign hs        = |arb_gnt;

  always_comb begin
    sel_src1 = '0;
    sel_src2 = '0;
    sel_ctrl = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (arb_gnt[i]) begin
        sel_src1 = req_src1[i*32 +: 32];
        sel_src2 = req_src2[i*32 +: 32];
        sel_ctrl = req_ctrl[i*4 +: 4];
      end
    end
  end

  alu u_alu (
    .rst_n       (rst_n),
    .src1        (op_src1_q),
    .src2        (op_src2_q),
    .ALU_control (op_ctrl_q),
    .result      (alu_result),
    .zero        (alu_zero),
    .cout        (alu_cout),
    .overflow    (alu_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      op_src1_q       <= '0;
      op_src2_q       <= '0;
      op_ctrl_q       <= '0;
      op_id_q         <= '0;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= '0;
      resp_result_q   <= '0;
      resp_zero_q     <= 1'b0;
      resp_cout_q     <= 1'b0;
      resp_overflow_q <= 1'b0;
      resp_illegal_q  <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      ptr_q           <= '0;
`endif
    end else begin
      // Handshakes only happen in IDLE or in RESP while the response is taken.
      if (hs) begin
        op_src1_q <= sel_src1;
        op_src2_q <= sel_src2;
        op_ctrl_q <= sel_ctrl;
        op_id_q   <= arb_idx;
`ifndef ALU_SHARE_FIXED_PRIO_EN
        ptr_q     <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
`endif
      end

      case (state_q)
        ST_IDLE: begin
          if (hs) state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          resp_valid_q <= 1'b1;
          resp_id_q    <= op_id_q;
          if (is_legal_op(op_ctrl_q)) begin
            resp_result_q   <= alu_result;
            resp_zero_q     <= alu_zero;
            resp_cout_q     <= alu_cout;
            resp_overflow_q <= alu_overflow;
            resp_illegal_q  <= 1'b0;
          end else begin
            resp_result_q   <= '0;
            resp_zero_q     <= 1'b1;
            resp_cout_q     <= 1'b0;
            resp_overflow_q <= 1'b0;
            resp_illegal_q  <= 1'b1;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= hs ? ST_EXEC : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_result   = resp_result_q;
  assign resp_zero     = resp_zero_q;
  assign resp_cout     = resp_cout_q;
  assign resp_overflow = resp_overflow_q;
  assign resp_illegal  = resp_illegal_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed testbench for alu_share_ctrl: a vector table of single operations plus
// hand-written sequences for contention, response stall, reset mid-op and arbitration.
module tb_alu_share_ctrl;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ID_W    = 1;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_src1;
  logic [NUM_REQ*32-1:0] req_src2;
  logic [NUM_REQ*4-1:0]  req_ctrl;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_result;
  logic                  resp_zero;
  logic                  resp_cout;
  logic                  resp_overflow;
  logic                  resp_illegal;

  alu_share_ctrl #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_src1      (req_src1),
    .req_src2      (req_src2),
    .req_ctrl      (req_ctrl),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_result   (resp_result),
    .resp_zero     (resp_zero),
    .resp_cout     (resp_cout),
    .resp_overflow (resp_overflow),
    .resp_illegal  (resp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:0]  id;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        ill;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ctrl);
    req_valid[id]       = 1'b1;
    req_src1[id*32 +: 32] = a;
    req_src2[id*32 +: 32] = b;
    req_ctrl[id*4 +: 4]   = ctrl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_resp(input string tag, input logic [0:0] id, input logic [31:0] res,
                            input logic z, input logic c, input logic v, input logic ill);
    check({tag, " resp_valid"},    32'(resp_valid),    32'd1);
    check({tag, " resp_id"},       32'(resp_id),       32'(id));
    check({tag, " resp_result"},   resp_result,        res);
    check({tag, " resp_zero"},     32'(resp_zero),     32'(z));
    check({tag, " resp_cout"},     32'(resp_cout),     32'(c));
    check({tag, " resp_overflow"}, 32'(resp_overflow), 32'(v));
    check({tag, " resp_illegal"},  32'(resp_illegal),  32'(ill));
  endtask

  // One isolated op: handshake, EXEC gap, response two cycles later, then drain.
  task automatic do_op(input string tag, input vec_t v);
    bit got = 0;
    @(negedge clk);
    resp_ready = 1'b0;
    set_req(int'(v.id), v.a, v.b, v.ctrl);
    #1;
    for (int k = 0; k < 10; k++) begin
      if (req_ready[v.id]) begin
        got = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s handshake timeout: req_ready=%b, expected grant to %0d", tag,
               req_ready, v.id);
    end
    check({tag, " req_ready onehot"}, 32'(req_ready), 32'(1) << v.id);
    @(negedge clk);
    req_valid = '0;
    #1;
    check({tag, " resp_valid at T+1"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    #1;
    check_resp(tag, v.id, v.res, v.z, v.c, v.v, v.ill);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    check({tag, " resp_valid after accept"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vb;
    logic [1:0] grants [4];
    logic [1:0] exp_g  [4];
    int ng;

    //          id    ctrl     a             b             res           z     c     v     ill
    vecs[0]  = {1'b0, 4'b0010, 32'd5,        32'd3,        32'd8,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = {1'b1, 4'b0110, 32'd7,        32'd7,        32'd0,        1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = {1'b0, 4'b0001, 32'hF0,       32'h0F,       32'hFF,       1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = {1'b1, 4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = {1'b0, 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = {1'b1, 4'b1100, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = {1'b0, 4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = {1'b0, 4'b1111, 32'h12,       32'd0,        32'd0,        1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = {1'b1, 4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = {1'b0, 4'b0010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = {1'b1, 4'b0110, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = {1'b0, 4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = {1'b1, 4'b0011, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 1'b0, 1'b1};

    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_src1   = '0;
    req_src2   = '0;
    req_ctrl   = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    // Reset state, with requests pending to show ready stays low.
    check("reset req_ready",     32'(req_ready),     32'd0);
    check("reset resp_valid",    32'(resp_valid),    32'd0);
    check("reset resp_id",       32'(resp_id),       32'd0);
    check("reset resp_result",   resp_result,        32'd0);
    check("reset resp_flags",    32'({resp_zero, resp_cout, resp_overflow, resp_illegal}), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Contention after reset: req0 first, req1 back-to-back two cycles later.
    do_reset();
    @(negedge clk);
    set_req(0, 32'd7, 32'd7, 4'b0110);
    set_req(1, 32'hF0, 32'h0F, 4'b0001);
    resp_ready = 1'b1;
    #1;
    check("b2b first grant", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    check("b2b exec0 resp_valid", 32'(resp_valid), 32'd0);
    check("b2b exec0 req_ready",  32'(req_ready),  32'd0);
    @(negedge clk);
    #1;
    check_resp("b2b op0", 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("b2b second grant", 32'(req_ready), 32'b10);
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    check("b2b exec1 resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    #1;
    check_resp("b2b op1", 1'b1, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    check("b2b drained", 32'(resp_valid), 32'd0);

    // Response stall: result held, no grants while resp_ready is low.
    @(negedge clk);
    set_req(1, 32'hFFFFFFFF, 32'd1, 4'b0111);
    #1;
    check("stall grant", 32'(req_ready), 32'b10);
    @(negedge clk);
    req_valid[1] = 1'b0;
    set_req(0, 32'd1, 32'd1, 4'b0010);
    #1;
    check("stall exec req_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_resp($sformatf("stall cyc%0d", k), 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("stall cyc%0d req_ready", k), 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    check("stall release grant", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid  = '0;
    resp_ready = 1'b0;
    #1;
    check("stall next exec", 32'(resp_valid), 32'd0);
    @(negedge clk);
    #1;
    check_resp("stall next op", 1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset while in EXEC drops the op.
    @(negedge clk);
    set_req(0, 32'h7FFFFFFF, 32'd1, 4'b0010);
    #1;
    check("rst grant", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("rst exec resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst async resp_valid", 32'(resp_valid), 32'd0);
    check("rst async result",     resp_result,     32'd0);
    check("rst async flags",
          32'({resp_id, resp_zero, resp_cout, resp_overflow, resp_illegal}), 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst no resp %0d", k), 32'(resp_valid), 32'd0);
    end
    resp_ready = 1'b0;
    vb = {1'b0, 4'b0010, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    do_op("post-rst add", vb);

    // Arbitration with both requesters continuously valid.
    do_reset();
`ifdef ALU_SHARE_FIXED_PRIO_EN
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    @(negedge clk);
    set_req(0, 32'd0, 32'd0, 4'b0010);
    set_req(1, 32'd0, 32'd0, 4'b0010);
    resp_ready = 1'b1;
    ng = 0;
    #1;
    for (int k = 0; k < 30 && ng < 4; k++) begin
      if (req_ready != '0) begin
        grants[ng] = req_ready;
        ng++;
      end
      if (ng < 4) begin
        @(negedge clk);
        #1;
      end
    end
    check("arb grant count", 32'(ng), 32'd4);
    for (int k = 0; k < ng; k++) begin
      check($sformatf("arb grant %0d", k), 32'(grants[k]), 32'(exp_g[k]));
    end
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    resp_ready = 1'b0;
    #1;
    check("arb drained", 32'(resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
